mov8_sequencer: RTL and testbench

Bus-transfer initiator for the register unit. It decodes a MOV-8 instruction byte and drives the one-hot select and load strobes in relay-safe phases, so that one register drives the data bus and another latches it.
- Phase order: source selected, then settle, then load, then load dropped, then source released.
- It is the counterpart of the per-register ld/sel responders (A, B, C, D, M1, M2, X, Y) and is normally driven by the instruction-execute controller.

---
 rtl/mov8_sequencer_if.sv | 34 +++
 rtl/mov8_sequencer.sv | 140 ++++++++++++++
 tb/tb_mov8_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mov8_sequencer_if.sv
// mov8_sequencer bus bundle: start/instr request, select/load strobes, status.
// SEQ_ABORT_EN adds the abort input.
interface mov8_sequencer_if;
  logic       start;
  logic [7:0] instr;
  logic [7:0] sel;
  logic [7:0] ld;
  logic       busy;
  logic       done;
  logic       err;
`ifdef SEQ_ABORT_EN
  logic       abort;

  modport master (
    output start, instr, abort,
    input  sel, ld, busy, done, err
  );

  modport slave (
    input  start, instr, abort,
    output sel, ld, busy, done, err
  );
`else
  modport master (
    output start, instr,
    input  sel, ld, busy, done, err
  );

  modport slave (
    input  start, instr,
    output sel, ld, busy, done, err
  );
`endif
endinterface

// File: rtl/mov8_sequencer.sv
// MOV-8 transfer sequencer: sel, settle, load, drop load, release sel.
// Optional abort input enabled by SEQ_ABORT_EN.
module mov8_sequencer #(
  parameter int SETTLE    = 2,
  parameter int LD_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  mov8_sequencer_if.slave  bus
);

  localparam int MAXC = (SETTLE > LD_CYCLES) ? SETTLE : LD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    LOAD,
    HOLD,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    src, src_d;
  logic [2:0]    dst, dst_d;
  logic          abrt, abrt_d;
  logic          abort_w;

  logic [7:0]    sel_q, sel_d;
  logic [7:0]    ld_q, ld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

`ifdef SEQ_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    src_d   = src;
    dst_d   = dst;
    abrt_d  = abrt;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        abrt_d = 1'b0;
        if (bus.start) begin
          if (bus.instr[7:6] == 2'b00) begin
            src_d   = bus.instr[2:0];
            dst_d   = bus.instr[5:3];
            state_d = SEL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEL: begin
        if (abort_w) begin
          state_d = DONE;
          abrt_d  = 1'b1;
        end else if (cnt == CW'(SETTLE - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort_w) begin
          state_d = HOLD;
          abrt_d  = 1'b1;
        end else if (cnt == CW'(LD_CYCLES - 1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (abrt) begin
          state_d = IDLE;
        end else if (abort_w) begin
          state_d = DONE;
          abrt_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state || state == IDLE)
      cnt_d = '0;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    sel_d  = '0;
    ld_d   = '0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE) && !abrt_d;
    if ((state_d == SEL || state_d == LOAD || state_d == HOLD)
        && src_d != dst_d)
      sel_d = 8'd1 << src_d;
    if (state_d == LOAD)
      ld_d = 8'd1 << dst_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      src    <= '0;
      dst    <= '0;
      abrt   <= 1'b0;
      sel_q  <= '0;
      ld_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      src    <= src_d;
      dst    <= dst_d;
      abrt   <= abrt_d;
      sel_q  <= sel_d;
      ld_q   <= ld_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.ld   = ld_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_mov8_sequencer.sv
// Scoreboard bench for mov8_sequencer: defaults and SETTLE=1/LD_CYCLES=3.
// Per-cycle expected outputs are queued when a start is driven.
module tb_mov8_sequencer;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] ld;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] instr = 8'h00;

  always #5 clk = ~clk;

  mov8_sequencer_if b0();
  mov8_sequencer_if b1();

  assign b0.start = start;
  assign b0.instr = instr;
  assign b1.start = start;
  assign b1.instr = instr;
`ifdef SEQ_ABORT_EN
  assign b0.abort = 1'b0;
  assign b1.abort = 1'b0;
`endif

  mov8_sequencer dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  mov8_sequencer #(.SETTLE(1), .LD_CYCLES(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  obs_t q0[$];
  obs_t q1[$];
  obs_t p0 = '0;
  obs_t p1 = '0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(logic [7:0] s, logic [7:0] l,
                              logic b, logic d, logic e);
    obs_t o;
    o.sel  = s;
    o.ld   = l;
    o.busy = b;
    o.done = d;
    o.err  = e;
    return o;
  endfunction

  task automatic push(input int d, input obs_t o);
    if (d == 0) q0.push_back(o);
    else        q1.push_back(o);
  endtask

  task automatic push_xfer(input int d, input int s, input int l,
                           input logic [7:0] ins);
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] sv;
    logic [7:0] dv;
    src = ins[2:0];
    dst = ins[5:3];
    sv  = (src == dst) ? 8'h00 : (8'h01 << src);
    dv  = 8'h01 << dst;
    for (int i = 0; i < s; i++) push(d, mk(sv, 8'h00, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < l; i++) push(d, mk(sv, dv, 1'b1, 1'b0, 1'b0));
    push(d, mk(sv, 8'h00, 1'b1, 1'b0, 1'b0));
    push(d, mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0));
  endtask

  task automatic xfer_both(input logic [7:0] ins);
    push_xfer(0, 2, 2, ins);
    push_xfer(1, 1, 3, ins);
  endtask

  task automatic push_both(input obs_t o);
    push(0, o);
    push(1, o);
  endtask

  task automatic inv(input string t, input obs_t c, input obs_t p,
                     input logic rs);
    check({t, "_sel1h"}, 32'($onehot0(c.sel)), 32'd1);
    check({t, "_ld1h"}, 32'($onehot0(c.ld)), 32'd1);
    if (!rs) begin
      check({t, "_rise"},
            32'((c.ld != 0 && p.ld == 0) && (c.sel != 0 && p.sel == 0)),
            32'd0);
      check({t, "_fall"},
            32'((c.sel == 0 && p.sel != 0) && (c.ld != 0 || p.ld != 0)),
            32'd0);
    end
  endtask

  task automatic cyc();
    obs_t g0, g1, e0, e1;
    logic rs;
    @(posedge clk);
    #1;
    rs = reset;
    g0 = mk(b0.sel, b0.ld, b0.busy, b0.done, b0.err);
    g1 = mk(b1.sel, b1.ld, b1.busy, b1.done, b1.err);
    e0 = (q0.size() > 0) ? q0.pop_front() : '0;
    e1 = (q1.size() > 0) ? q1.pop_front() : '0;
    check("d0_out", 32'(g0), 32'(e0));
    check("d1_out", 32'(g1), 32'(e1));
    inv("d0", g0, p0, rs);
    inv("d1", g1, p1, rs);
    p0 = g0;
    p1 = g1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q0.size() > 0 || q1.size() > 0); i++)
      cyc();
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
    cyc();
  endtask

  task automatic one_start(input logic [7:0] ins);
    instr = ins;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    cyc();

    // dst=A src=C; a valid start while busy must be ignored
    xfer_both(8'h02);
    one_start(8'h02);
    instr = 8'hFF;
    cyc();
    start = 1'b1;
    instr = 8'h1B;
    cyc();
    start = 1'b0;
    drain();

    // clear operation
    xfer_both(8'h1B);
    one_start(8'h1B);
    drain();

    // bad opcode class
    push_both(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
    one_start(8'hC5);
    drain();

    // start held high: two transfers one idle cycle apart
    xfer_both(8'h0A);
    push_both('0);
    xfer_both(8'h0A);
    instr = 8'h0A;
    start = 1'b1;
    repeat (8) cyc();
    start = 1'b0;
    drain();

    // reset in first LOAD cycle of the default instance
    xfer_both(8'h02);
    one_start(8'h02);
    cyc();
    cyc();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    cyc();
    reset = 1'b0;
    cyc();
    xfer_both(8'h11);
    one_start(8'h11);
    drain();

    for (int k = 0; k < 4; k++) begin
      logic [7:0] ri;
      ri = 8'($urandom_range(0, 63));
      xfer_both(ri);
      one_start(ri);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
